spi_command_trace_buffer: RTL and testbench

Parametrised capture buffer for commands decoded by the SPI slave receiver, read back over an Avalon-MM slave port. Each rising edge of the receiver's read-success strobe stores one timestamped entry. The buffer runs in wrap (overwrite oldest) or stop-on-full mode and counts lost commands. Entries are addressed oldest-first, so software never needs to unroll the pointer itself.

---
 rtl/spi_trace_pkg.sv | 20 ++
 rtl/spi_trace_ram.sv | 27 ++
 rtl/spi_command_trace_buffer.sv | 146 ++++++++++++++
 tb/tb_spi_command_trace_buffer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_trace_pkg.sv
// rtl/spi_trace_pkg.sv - register map, CONTROL bit positions and entry packing for the SPI command trace buffer
package spi_trace_pkg;

  localparam int REG_STATUS    = 0;
  localparam int REG_CONTROL   = 1;
  localparam int REG_OVERFLOW  = 2;
  localparam int REG_TIMESTAMP = 3;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_STOP   = 1;
  localparam int CTRL_CLEAR  = 2;

  // Entry layout, LSB first: argument, command, timestamp; caller truncates to the stored width.
  function automatic logic [63:0] pack_entry(input logic [63:0] ts, input logic [63:0] cmd,
                                             input logic [63:0] arg, input int cmd_w,
                                             input int arg_w);
    return (ts << (cmd_w + arg_w)) | (cmd << arg_w) | arg;
  endfunction

endpackage

// File: rtl/spi_trace_ram.sv
// rtl/spi_trace_ram.sv - trace entry storage, one write port and one registered read port
module spi_trace_ram #(
  parameter  int DEPTH = 64,
  parameter  int WIDTH = 54,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [PW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [PW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Read and write share one edge, so a read of the slot being written returns the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_command_trace_buffer.sv
// rtl/spi_command_trace_buffer.sv - timestamped capture of SPI receiver commands, read oldest-first over Avalon-MM
module spi_command_trace_buffer
  import spi_trace_pkg::*;
#(
  parameter  int DEPTH = 64,
  parameter  int CMD_W = 6,
  parameter  int ARG_W = 32,
  parameter  int TS_W  = 16,
  localparam int AW    = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [AW-1:0]    io_Avalon_address,
  input  logic             io_Avalon_read,
  input  logic             io_Avalon_write,
  input  logic [63:0]      io_Avalon_writedata,
  output logic [63:0]      io_Avalon_readdata,
  output logic             io_Avalon_readdatavalid,
  output logic             io_Avalon_waitrequest,
  input  logic [CMD_W-1:0] io_Command,
  input  logic [ARG_W-1:0] io_CommandArgument,
  input  logic             io_ReadSuccess
);

  localparam int PW = AW - 1;
  localparam int EW = TS_W + CMD_W + ARG_W;

  if (EW > 64 || DEPTH < 4 || DEPTH > 1024 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
    $error("spi_command_trace_buffer: illegal DEPTH or entry width");
  end

  logic            hist_q;
  logic [TS_W-1:0] ts_q;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic [31:0]     overflow_q, overflow_d;
  logic            enable_q, stop_q;
  logic            waitreq_q, rvalid_q;
  logic            sel_entry_q, entry_ok_q;
  logic [63:0]     reg_rdata_q;

  logic            rs_edge, wr_acc, rd_acc, is_entry, ctrl_wr, clear_w;
  logic            full_w, take, store;
  logic [PW-1:0]   idx, raddr;
  logic [63:0]     entry_w, reg_val;
  logic [EW-1:0]   ram_rdata;
  logic            unused_wdata;

  assign rs_edge  = io_ReadSuccess & ~hist_q;
  assign wr_acc   = io_Avalon_write & ~waitreq_q;
  assign rd_acc   = io_Avalon_read & ~io_Avalon_write & ~waitreq_q;
  assign is_entry = io_Avalon_address[AW-1];
  assign idx      = io_Avalon_address[PW-1:0];
  assign ctrl_wr  = wr_acc & ~is_entry & (idx == PW'(REG_CONTROL));
  assign clear_w  = ctrl_wr & io_Avalon_writedata[CTRL_CLEAR];
  // count never exceeds DEPTH, so its MSB alone flags a full buffer.
  assign full_w   = count_q[PW];
  assign take     = rs_edge & enable_q & ~clear_w;
  assign store    = take & ~(full_w & stop_q);
  assign raddr    = wr_ptr_q - count_q[PW-1:0] + idx;
  assign entry_w  = pack_entry(64'(ts_q), 64'(io_Command), 64'(io_CommandArgument), CMD_W, ARG_W);
  assign unused_wdata = ^io_Avalon_writedata[63:3];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear_w) begin
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = '0;
    end else if (take) begin
      if (store) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (!full_w) count_d = count_q + 1'b1;
      end
      if (full_w && overflow_q != '1) overflow_d = overflow_q + 32'd1;
    end
  end

  always_comb begin
    reg_val = '0;
    if (idx == PW'(REG_STATUS)) begin
      reg_val = 64'(count_q) | (64'(wr_ptr_q) << 16) | (64'(full_w) << 32) |
                (64'(overflow_q != '0) << 33);
    end else if (idx == PW'(REG_CONTROL)) begin
      reg_val = 64'({stop_q, enable_q});
    end else if (idx == PW'(REG_OVERFLOW)) begin
      reg_val = 64'(overflow_q);
    end else if (idx == PW'(REG_TIMESTAMP)) begin
      reg_val = 64'(ts_q);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hist_q      <= 1'b1;
      ts_q        <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= '0;
      enable_q    <= 1'b1;
      stop_q      <= 1'b0;
      waitreq_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      sel_entry_q <= 1'b0;
      entry_ok_q  <= 1'b0;
      reg_rdata_q <= '0;
    end else begin
      hist_q     <= io_ReadSuccess;
      ts_q       <= ts_q + 1'b1;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      waitreq_q  <= store;
      rvalid_q   <= rd_acc;
      if (ctrl_wr) begin
        enable_q <= io_Avalon_writedata[CTRL_ENABLE];
        stop_q   <= io_Avalon_writedata[CTRL_STOP];
      end
      if (rd_acc) begin
        sel_entry_q <= is_entry;
        entry_ok_q  <= ({1'b0, idx} < count_q);
        reg_rdata_q <= reg_val;
      end
    end
  end

  spi_trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (store),
    .waddr_i (wr_ptr_q),
    .wdata_i (EW'(entry_w)),
    .re_i    (rd_acc & is_entry),
    .raddr_i (raddr),
    .rdata_o (ram_rdata)
  );

  assign io_Avalon_readdata      = sel_entry_q ? (entry_ok_q ? 64'(ram_rdata) : 64'd0) : reg_rdata_q;
  assign io_Avalon_readdatavalid = rvalid_q;
  assign io_Avalon_waitrequest   = waitreq_q;

endmodule

// File: tb/tb_spi_command_trace_buffer.sv
// tb/tb_spi_command_trace_buffer.sv - directed and random stimulus against a queue model of the trace buffer
module tb_spi_command_trace_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic          read, write;
  logic [63:0]   writedata;
  logic [63:0]   readdata;
  logic          readdatavalid, waitrequest;
  logic [5:0]    cmd;
  logic [31:0]   arg;
  logic          rs;

  always #5 clock = ~clock;

  spi_command_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .io_Avalon_address       (address),
    .io_Avalon_read          (read),
    .io_Avalon_write         (write),
    .io_Avalon_writedata     (writedata),
    .io_Avalon_readdata      (readdata),
    .io_Avalon_readdatavalid (readdatavalid),
    .io_Avalon_waitrequest   (waitrequest),
    .io_Command              (cmd),
    .io_CommandArgument      (arg),
    .io_ReadSuccess          (rs)
  );

  int vectors     = 0;
  int miscompares = 0;
  int tcount      = 0;

  logic [63:0] m_q[$];
  int          m_wp;
  longint      m_ovf;
  bit          m_en, m_stop;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    if (!reset) tcount++;
  endtask

  task automatic model_clear();
    m_q.delete();
    m_wp  = 0;
    m_ovf = 0;
  endtask

  task automatic model_ctrl(input logic [63:0] d);
    m_en   = d[0];
    m_stop = d[1];
    if (d[2]) model_clear();
  endtask

  task automatic model_capture(input logic [5:0] c, input logic [31:0] a, input int t, output bit stored);
    logic [15:0] ts16;
    logic [63:0] e;
    ts16 = 16'(t);
    e = (64'(ts16) << 38) | (64'(c) << 32) | 64'(a);
    stored = 0;
    if (m_en) begin
      if (m_q.size() < DEPTH) begin
        m_q.push_back(e);
        m_wp = (m_wp + 1) % DEPTH;
        stored = 1;
      end else begin
        if (m_ovf != 64'hFFFF_FFFF) m_ovf++;
        if (!m_stop) begin
          void'(m_q.pop_front());
          m_q.push_back(e);
          m_wp = (m_wp + 1) % DEPTH;
          stored = 1;
        end
      end
    end
  endtask

  function automatic logic [63:0] exp_entry(input int i);
    return (i < m_q.size()) ? m_q[i] : 64'd0;
  endfunction

  function automatic logic [63:0] exp_status();
    logic [63:0] s;
    s = 64'(m_q.size()) | (64'(m_wp) << 16);
    if (m_q.size() == DEPTH) s[32] = 1'b1;
    if (m_ovf != 0) s[33] = 1'b1;
    return s;
  endfunction

  task automatic pulse(input logic [5:0] c, input logic [31:0] a);
    bit st;
    rs = 1'b1; cmd = c; arg = a;
    model_capture(c, a, tcount, st);
    step();
    if (st) check("wait_after_capture", 64'(waitrequest), 64'd1);
    rs = 1'b0;
    step();
  endtask

  task automatic avm_read(input logic [AW-1:0] a, output logic [63:0] d);
    int n = 0;
    address = a; read = 1'b1;
    while (waitrequest && n < 8) begin step(); n++; end
    check("read_stall_timeout", 64'(waitrequest), 64'd0);
    step();
    read = 1'b0;
    check("read_rvalid", 64'(readdatavalid), 64'd1);
    d = readdata;
  endtask

  task automatic read_chk(input string tag, input logic [AW-1:0] a, input logic [63:0] exp);
    logic [63:0] d;
    avm_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic avm_write(input logic [AW-1:0] a, input logic [63:0] d);
    int n = 0;
    address = a; write = 1'b1; writedata = d;
    while (waitrequest && n < 8) begin step(); n++; end
    check("write_stall_timeout", 64'(waitrequest), 64'd0);
    if (a == 3'd1) model_ctrl(d);
    step();
    write = 1'b0;
  endtask

  task automatic read_all_entries(input string tag);
    for (int i = 0; i < DEPTH; i++) read_chk(tag, 3'(4 + i), exp_entry(i));
    read_chk({tag, "_status"}, 3'd0, exp_status());
    read_chk({tag, "_overflow"}, 3'd2, 64'(m_ovf));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] d;
    bit st;
    int t, r;
    rs = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    cmd = '0; arg = '0; reset = 1'b1;
    m_en = 1; m_stop = 0; model_clear();

    repeat (3) @(posedge clock);
    #1;
    check("rst_readdata", readdata, 64'd0);
    check("rst_rvalid", 64'(readdatavalid), 64'd0);
    check("rst_waitreq", 64'(waitrequest), 64'd0);
    reset = 1'b0; tcount = 0;
    step(); step();
    rs = 1'b0;
    step();
    read_chk("rst_status", 3'd0, 64'd0);
    read_chk("rst_control", 3'd1, 64'h1);

    // Basic capture
    for (int n = 1; n <= 3; n++) pulse(6'(n), 32'(32'hA0 + n));
    read_all_entries("basic");
    avm_read(3'd0, d);
    check("basic_count", 64'(d[15:0]), 64'd3);
    avm_read(3'd4, d);
    check("basic_e0_arg", 64'(d[31:0]), 64'hA1);

    // Wrap mode
    avm_write(3'd1, 64'h5);
    for (int n = 1; n <= 6; n++) pulse(6'(n), $urandom);
    read_all_entries("wrap");
    avm_read(3'd4, d);
    check("wrap_e0_cmd", 64'(d[37:32]), 64'd3);
    avm_read(3'd7, d);
    check("wrap_e3_cmd", 64'(d[37:32]), 64'd6);
    read_chk("wrap_ovf2", 3'd2, 64'd2);

    // Stop mode
    avm_write(3'd1, 64'h7);
    for (int n = 1; n <= 6; n++) pulse(6'(n), $urandom);
    read_all_entries("stop");
    avm_read(3'd7, d);
    check("stop_e3_cmd", 64'(d[37:32]), 64'd4);
    avm_read(3'd0, d);
    check("stop_wrptr", 64'(d[31:16]), 64'd0);

    // Clear in the same cycle as an edge: clear wins
    address = 3'd1; writedata = 64'h5; write = 1'b1;
    rs = 1'b1; cmd = 6'($urandom); arg = $urandom;
    model_ctrl(64'h5);
    step();
    write = 1'b0; rs = 1'b0;
    check("clear_no_wait", 64'(waitrequest), 64'd0);
    step();
    read_chk("clear_status", 3'd0, 64'd0);
    read_chk("clear_ovf", 3'd2, 64'd0);
    pulse(6'h2A, $urandom);
    avm_read(3'd4, d);
    check("clear_e0_cmd", 64'(d[37:32]), 64'h2A);
    check("clear_e0", d, exp_entry(0));

    // Read issued during the waitrequest cycle is held one cycle
    rs = 1'b1; cmd = 6'($urandom); arg = $urandom;
    model_capture(cmd, arg, tcount, st);
    step();
    check("stress_wait", 64'(waitrequest), 64'd1);
    rs = 1'b0; address = 3'd0; read = 1'b1;
    step();
    check("stress_held", 64'(readdatavalid), 64'd0);
    step();
    read = 1'b0;
    check("stress_rvalid", 64'(readdatavalid), 64'd1);
    check("stress_status", readdata, exp_status());

    // Disabled edge is neither stored nor counted
    avm_write(3'd1, 64'h0);
    pulse(6'h11, $urandom);
    read_chk("dis_status", 3'd0, exp_status());
    read_chk("dis_ovf", 3'd2, 64'(m_ovf));
    avm_write(3'd1, 64'h1);

    // Back-to-back entry reads
    address = 3'd4; read = 1'b1;
    step();
    check("b2b_v0", 64'(readdatavalid), 64'd1);
    check("b2b_d0", readdata, exp_entry(0));
    address = 3'd5;
    step();
    read = 1'b0;
    check("b2b_v1", 64'(readdatavalid), 64'd1);
    check("b2b_d1", readdata, exp_entry(1));
    step();
    check("b2b_idle", 64'(readdatavalid), 64'd0);

    // Read and write together: only the write happens
    address = 3'd1; read = 1'b1; write = 1'b1; writedata = 64'h3;
    model_ctrl(64'h3);
    step();
    read = 1'b0; write = 1'b0;
    check("rw_no_rvalid", 64'(readdatavalid), 64'd0);
    read_chk("rw_control", 3'd1, 64'h3);
    avm_write(3'd1, 64'h1);

    // Writes to entries and read-only registers are ignored
    avm_write(3'd4, 64'hFFFF_FFFF_FFFF_FFFF);
    avm_write(3'd2, 64'h5);
    read_chk("ro_entry", 3'd4, exp_entry(0));
    read_chk("ro_ovf", 3'd2, 64'(m_ovf));
    t = tcount;
    read_chk("timestamp", 3'd3, 64'(16'(t)));

    // Random traffic
    repeat (80) begin
      r = $urandom_range(0, 9);
      if (r <= 4) pulse(6'($urandom), $urandom);
      else if (r <= 6) begin
        t = $urandom_range(0, DEPTH - 1);
        read_chk("rnd_entry", 3'(4 + t), exp_entry(t));
      end else if (r == 7) read_chk("rnd_status", 3'd0, exp_status());
      else if (r == 8) read_chk("rnd_ovf", 3'd2, 64'(m_ovf));
      else begin
        d = '0;
        d[0] = ($urandom_range(0, 3) != 0);
        d[1] = $urandom_range(0, 1);
        d[2] = ($urandom_range(0, 3) == 0);
        avm_write(3'd1, d);
        read_chk("rnd_control", 3'd1, 64'({m_stop, m_en}));
      end
    end
    read_all_entries("rnd_final");

    // Reset mid-operation cancels the in-flight result
    address = 3'd4; read = 1'b1;
    step();
    read = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_rvalid", 64'(readdatavalid), 64'd0);
    check("midrst_readdata", readdata, 64'd0);
    check("midrst_waitreq", 64'(waitrequest), 64'd0);
    m_en = 1; m_stop = 0; model_clear();
    step();
    reset = 1'b0; tcount = 0;
    step();
    read_chk("midrst_status", 3'd0, 64'd0);
    read_chk("midrst_control", 3'd1, 64'h1);
    t = tcount;
    read_chk("midrst_ts", 3'd3, 64'(16'(t)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
